// File: rtl/deco_grey_floor_sync_pkg.sv
// Shared state and direction encodings for the Grey floor synchroniser/decoder.
package deco_grey_floor_sync_pkg;

  typedef enum logic [1:0] {
    ST_INIT  = 2'd0,
    ST_TRACK = 2'd1,
    ST_FAULT = 2'd2
  } state_e;

  localparam logic [1:0] DIR_NONE = 2'b00;
  localparam logic [1:0] DIR_UP   = 2'b01;
  localparam logic [1:0] DIR_DOWN = 2'b10;

endpackage

// File: rtl/deco_grey_floor_sync_to_bin_n.sv
// Purely combinational WIDTH-bit Grey to binary converter.
module deco_grey_floor_sync_to_bin_n #(
  parameter int unsigned WIDTH = 3
) (
  input  logic [WIDTH-1:0] gray,
  output logic [WIDTH-1:0] bin
);

  // Each binary bit is the XOR of all Grey bits at and above it.
  always_comb begin
    bin = '0;
    for (int i = 0; i < int'(WIDTH); i++) begin
      bin[i] = ^(gray >> i);
    end
  end

endmodule

// File: rtl/deco_grey_floor_sync.sv
// Synchronises, debounces and validates a Grey-coded cabin position sensor.
// Optional direction detection and magnitude step check: `GREY_DIR_DETECT_EN.
module deco_grey_floor_sync
  import deco_grey_floor_sync_pkg::*;
#(
  parameter int unsigned WIDTH         = 3,
  parameter int unsigned STABLE_CYCLES = 4
) (
  input  logic             clk_i,
  input  logic             reset_i,
  input  logic [WIDTH-1:0] gray_i,
  input  logic             sample_en_i,
  input  logic             clear_err_i,
  output logic [WIDTH-1:0] bin_o,
  output logic             valid_o,
  output logic             changed_o,
  output logic [1:0]       dir_o,
  output logic             err_o
);

  localparam int unsigned CW = $clog2(STABLE_CYCLES + 1);

  logic [WIDTH-1:0] s1;
  logic [WIDTH-1:0] s2;
  logic [WIDTH-1:0] cand;
  logic [CW-1:0]    count;
  state_e           state;
  state_e           state_n;

  logic [WIDTH-1:0] bin_n;
  logic             valid_n;
  logic             changed_n;
  logic [1:0]       dir_n;
  logic             err_n;

  logic [WIDTH-1:0] new_bin;
  logic [WIDTH-1:0] old_gray;
  logic             clear;
  logic             accept;
  logic             one_bit;
  logic             step_ok;

  // The accepted value is always the current s2 sample, so convert that.
  deco_grey_floor_sync_to_bin_n #(.WIDTH(WIDTH)) u_to_bin (
    .gray (s2),
    .bin  (new_bin)
  );

  assign clear    = clear_err_i && (state == ST_FAULT);
  assign old_gray = bin_o ^ (bin_o >> 1);
  assign one_bit  = ($countones(s2 ^ old_gray) == 1);

  // Accept on the tick the value is seen for the STABLE_CYCLES-th time in a row.
  always_comb begin
    accept = 1'b0;
    if (sample_en_i && !clear) begin
      if (s2 != cand) accept = (STABLE_CYCLES == 1);
      else            accept = (count == CW'(STABLE_CYCLES - 1));
    end
  end

`ifdef GREY_DIR_DETECT_EN
  logic is_up;
  logic is_down;

  assign is_up   = (bin_o != '1) && (new_bin == bin_o + WIDTH'(1));
  assign is_down = (bin_o != '0) && (new_bin == bin_o - WIDTH'(1));
  assign step_ok = one_bit && (is_up || is_down);
`else
  logic is_wrap;

  assign is_wrap = ((bin_o == '0) && (new_bin == '1)) ||
                   ((bin_o == '1) && (new_bin == '0));
  assign step_ok = one_bit && !is_wrap;
`endif

  // Two-flop synchroniser followed by the saturating debounce counter.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      s1    <= '0;
      s2    <= '0;
      cand  <= '0;
      count <= '0;
    end else begin
      s1 <= gray_i;
      s2 <= s1;
      if (clear) begin
        count <= '0;
      end else if (sample_en_i) begin
        if (s2 != cand) begin
          cand  <= s2;
          count <= CW'(1);
        end else if (count != CW'(STABLE_CYCLES)) begin
          count <= count + CW'(1);
        end
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state     <= ST_INIT;
      bin_o     <= '0;
      valid_o   <= 1'b0;
      changed_o <= 1'b0;
      dir_o     <= DIR_NONE;
      err_o     <= 1'b0;
    end else begin
      state     <= state_n;
      bin_o     <= bin_n;
      valid_o   <= valid_n;
      changed_o <= changed_n;
      dir_o     <= dir_n;
      err_o     <= err_n;
    end
  end

  always_comb begin
    state_n   = state;
    bin_n     = bin_o;
    valid_n   = valid_o;
    changed_n = 1'b0;
    dir_n     = dir_o;
    err_n     = err_o;
    unique case (state)
      ST_INIT: begin
        if (accept) begin
          bin_n     = new_bin;
          valid_n   = 1'b1;
          changed_n = 1'b1;
          dir_n     = DIR_NONE;
          state_n   = ST_TRACK;
        end
      end
      ST_TRACK: begin
        if (accept && (new_bin != bin_o)) begin
          if (step_ok) begin
            bin_n     = new_bin;
            changed_n = 1'b1;
`ifdef GREY_DIR_DETECT_EN
            dir_n     = is_up ? DIR_UP : DIR_DOWN;
`else
            dir_n     = DIR_NONE;
`endif
          end else begin
            err_n   = 1'b1;
            valid_n = 1'b0;
            state_n = ST_FAULT;
          end
        end
      end
      ST_FAULT: begin
        if (clear_err_i) begin
          err_n   = 1'b0;
          state_n = ST_INIT;
        end
      end
      default: begin
        state_n = ST_INIT;
      end
    endcase
  end

endmodule

// File: tb/tb_deco_grey_floor_sync.sv
// Randomised and directed bench for deco_grey_floor_sync against a floor-level model.
module tb_deco_grey_floor_sync;

  localparam int unsigned W    = 3;
  localparam int unsigned SC   = 4;
  localparam int          MAXV = (1 << W) - 1;

  logic         clk_i = 1'b0;
  logic         reset_i;
  logic [W-1:0] gray_i;
  logic         sample_en_i;
  logic         clear_err_i;
  logic [W-1:0] bin_o;
  logic         valid_o;
  logic         changed_o;
  logic [1:0]   dir_o;
  logic         err_o;

  int asserts = 0;
  int fails   = 0;

  // Model: pipeline of raw samples, run length of the current candidate, floor-level state.
  int m_s1, m_s2, m_cand, m_run, m_mode;
  int m_bin, m_valid, m_changed, m_dir, m_err;

  always #5 clk_i = ~clk_i;

  deco_grey_floor_sync #(.WIDTH(W), .STABLE_CYCLES(SC)) dut (
    .clk_i       (clk_i),
    .reset_i     (reset_i),
    .gray_i      (gray_i),
    .sample_en_i (sample_en_i),
    .clear_err_i (clear_err_i),
    .bin_o       (bin_o),
    .valid_o     (valid_o),
    .changed_o   (changed_o),
    .dir_o       (dir_o),
    .err_o       (err_o)
  );

  function automatic int g2b(input int g);
    int b = g;
    for (int s = g >> 1; s != 0; s = s >> 1) b ^= s;
    return b;
  endfunction

  function automatic int b2g(input int b);
    return b ^ (b >> 1);
  endfunction

  function automatic bit legal_step(input int oldb, input int newb);
`ifdef GREY_DIR_DETECT_EN
    return (newb - oldb == 1) || (oldb - newb == 1);
`else
    bit wrap;
    wrap = (oldb == 0 && newb == MAXV) || (oldb == MAXV && newb == 0);
    return ($countones(b2g(oldb) ^ b2g(newb)) == 1) && !wrap;
`endif
  endfunction

  function automatic void model_step(input bit r, input int g, input bit se, input bit cl);
    int  seen, prev, nb;
    bit  acc, clr_now;
    if (r) begin
      m_s1 = 0; m_s2 = 0; m_cand = 0; m_run = 0; m_mode = 0;
      m_bin = 0; m_valid = 0; m_changed = 0; m_dir = 0; m_err = 0;
      return;
    end
    seen    = m_s2;
    m_s2    = m_s1;
    m_s1    = g;
    clr_now = cl && (m_mode == 2);
    acc     = 1'b0;
    if (clr_now) begin
      m_run = 0;
    end else if (se) begin
      prev = m_run;
      if (seen != m_cand) begin
        m_cand = seen;
        m_run  = 1;
        acc    = (SC == 1);
      end else begin
        if (m_run < int'(SC)) m_run++;
        acc = (prev < int'(SC)) && (m_run == int'(SC));
      end
    end
    m_changed = 0;
    nb = g2b(seen);
    case (m_mode)
      0: if (acc) begin
        m_bin = nb; m_valid = 1; m_changed = 1; m_dir = 0; m_mode = 1;
      end
      1: if (acc && nb != m_bin) begin
        if (legal_step(m_bin, nb)) begin
`ifdef GREY_DIR_DETECT_EN
          m_dir = (nb > m_bin) ? 1 : 2;
`else
          m_dir = 0;
`endif
          m_bin = nb; m_changed = 1;
        end else begin
          m_err = 1; m_valid = 0; m_mode = 2;
        end
      end
      default: if (cl) begin
        m_err = 0; m_mode = 0;
      end
    endcase
  endfunction

  function automatic logic [W+4:0] exp_vec();
    return {W'(m_bin), 1'(m_valid), 1'(m_changed), 2'(m_dir), 1'(m_err)};
  endfunction

  task automatic tick();
    bit r, se, cl;
    int g;
    r  = reset_i;
    g  = int'(gray_i);
    se = sample_en_i;
    cl = clear_err_i;
    @(posedge clk_i);
    model_step(r, g, se, cl);
    #1;
  endtask

  task automatic test_reset();
    reset_i = 1'b1; gray_i = '0; sample_en_i = 1'b1; clear_err_i = 1'b0;
    tick(); tick();
    asserts++;
    if ({bin_o, valid_o, changed_o, dir_o, err_o} !== '0)
      $display("FAIL reset_values got=%h want=0", {bin_o, valid_o, changed_o, dir_o, err_o});
    if ({bin_o, valid_o, changed_o, dir_o, err_o} !== '0) fails++;
    reset_i = 1'b0;
    for (int i = 0; i < 8; i++) begin
      tick();
      asserts++;
      if ({bin_o, valid_o, changed_o, dir_o, err_o} !== exp_vec()) begin
        $display("FAIL reset_acquire t=%0t got=%h want=%h", $time,
                 {bin_o, valid_o, changed_o, dir_o, err_o}, exp_vec());
        fails++;
      end
    end
    asserts++;
    if (bin_o !== W'(0) || valid_o !== 1'b1 || dir_o !== 2'b00) begin
      $display("FAIL init_commit bin=%0d valid=%b dir=%b want bin=0 valid=1 dir=00",
               bin_o, valid_o, dir_o);
      fails++;
    end
  endtask

  task automatic test_step();
    int pulses;
    logic [1:0] want_up, want_dn;
`ifdef GREY_DIR_DETECT_EN
    want_up = 2'b01; want_dn = 2'b10;
`else
    want_up = 2'b00; want_dn = 2'b00;
`endif
    pulses = 0;
    gray_i = W'(1);
    for (int i = 0; i < 8; i++) begin
      tick();
      if (changed_o === 1'b1) pulses++;
      asserts++;
      if ({bin_o, valid_o, changed_o, dir_o, err_o} !== exp_vec()) begin
        $display("FAIL step_up t=%0t got=%h want=%h", $time,
                 {bin_o, valid_o, changed_o, dir_o, err_o}, exp_vec());
        fails++;
      end
    end
    asserts++;
    if (bin_o !== W'(1) || dir_o !== want_up || pulses != 1) begin
      $display("FAIL step_up_final bin=%0d dir=%b pulses=%0d want bin=1 dir=%b pulses=1",
               bin_o, dir_o, pulses, want_up);
      fails++;
    end
    gray_i = W'(3);
    repeat (8) tick();
    gray_i = W'(1);
    for (int i = 0; i < 8; i++) begin
      tick();
      asserts++;
      if ({bin_o, valid_o, changed_o, dir_o, err_o} !== exp_vec()) begin
        $display("FAIL step_down t=%0t got=%h want=%h", $time,
                 {bin_o, valid_o, changed_o, dir_o, err_o}, exp_vec());
        fails++;
      end
    end
    asserts++;
    if (bin_o !== W'(1) || dir_o !== want_dn) begin
      $display("FAIL step_down_final bin=%0d dir=%b want bin=1 dir=%b", bin_o, dir_o, want_dn);
      fails++;
    end
  endtask

  task automatic test_glitch();
    int pulses;
    pulses = 0;
    gray_i = W'(3);
    for (int i = 0; i < 12; i++) begin
      if (i == 2) gray_i = W'(1);
      tick();
      if (changed_o === 1'b1) pulses++;
      asserts++;
      if ({bin_o, valid_o, changed_o, dir_o, err_o} !== exp_vec()) begin
        $display("FAIL glitch t=%0t got=%h want=%h", $time,
                 {bin_o, valid_o, changed_o, dir_o, err_o}, exp_vec());
        fails++;
      end
    end
    asserts++;
    if (pulses != 0 || bin_o !== W'(1)) begin
      $display("FAIL glitch_final pulses=%0d bin=%0d want pulses=0 bin=1", pulses, bin_o);
      fails++;
    end
  endtask

  task automatic test_fault_clear();
    gray_i = W'(3);
    repeat (8) tick();
    gray_i = W'(6);
    for (int i = 0; i < 8; i++) begin
      tick();
      asserts++;
      if ({bin_o, valid_o, changed_o, dir_o, err_o} !== exp_vec()) begin
        $display("FAIL fault_enter t=%0t got=%h want=%h", $time,
                 {bin_o, valid_o, changed_o, dir_o, err_o}, exp_vec());
        fails++;
      end
    end
    asserts++;
    if (err_o !== 1'b1 || valid_o !== 1'b0 || bin_o !== W'(2)) begin
      $display("FAIL fault_state err=%b valid=%b bin=%0d want err=1 valid=0 bin=2",
               err_o, valid_o, bin_o);
      fails++;
    end
    clear_err_i = 1'b1;
    tick();
    clear_err_i = 1'b0;
    for (int i = 0; i < 4; i++) begin
      tick();
      asserts++;
      if ({bin_o, valid_o, changed_o, dir_o, err_o} !== exp_vec()) begin
        $display("FAIL fault_clear t=%0t got=%h want=%h", $time,
                 {bin_o, valid_o, changed_o, dir_o, err_o}, exp_vec());
        fails++;
      end
    end
    asserts++;
    if (valid_o !== 1'b1 || bin_o !== W'(4) || err_o !== 1'b0 || changed_o !== 1'b1) begin
      $display("FAIL reacquire valid=%b bin=%0d err=%b chg=%b want 1/4/0/1",
               valid_o, bin_o, err_o, changed_o);
      fails++;
    end
  endtask

  task automatic test_wrap();
    reset_i = 1'b1; gray_i = '0;
    tick();
    reset_i = 1'b0;
    repeat (8) tick();
    gray_i = W'(4);
    for (int i = 0; i < 8; i++) begin
      tick();
      asserts++;
      if ({bin_o, valid_o, changed_o, dir_o, err_o} !== exp_vec() || dir_o !== 2'b00) begin
        $display("FAIL wrap t=%0t got=%h want=%h", $time,
                 {bin_o, valid_o, changed_o, dir_o, err_o}, exp_vec());
        fails++;
      end
    end
    asserts++;
    if (err_o !== 1'b1 || valid_o !== 1'b0 || bin_o !== W'(0)) begin
      $display("FAIL wrap_fault err=%b valid=%b bin=%0d want err=1 valid=0 bin=0",
               err_o, valid_o, bin_o);
      fails++;
    end
  endtask

  task automatic test_reset_mid();
    reset_i = 1'b1; gray_i = '0;
    tick();
    reset_i = 1'b0;
    repeat (8) tick();
    gray_i = W'(1);
    repeat (5) tick();
    reset_i = 1'b1;
    tick();
    asserts++;
    if ({bin_o, valid_o, changed_o, dir_o, err_o} !== '0) begin
      $display("FAIL reset_mid got=%h want=0", {bin_o, valid_o, changed_o, dir_o, err_o});
      fails++;
    end
    reset_i = 1'b0;
    for (int i = 0; i < 10; i++) begin
      tick();
      asserts++;
      if ({bin_o, valid_o, changed_o, dir_o, err_o} !== exp_vec()) begin
        $display("FAIL reset_mid_reacq t=%0t got=%h want=%h", $time,
                 {bin_o, valid_o, changed_o, dir_o, err_o}, exp_vec());
        fails++;
      end
    end
  endtask

  task automatic test_random();
    int cur, hold, b;
    cur  = 0;
    hold = 0;
    for (int n = 0; n < 4000; n++) begin
      if (hold == 0) begin
        if ($urandom_range(0, 9) < 7) begin
          b   = g2b(cur);
          b   = ($urandom_range(0, 1) != 0) ? b + 1 : b - 1;
          cur = b2g(b & MAXV);
        end else begin
          cur = int'($urandom_range(0, MAXV));
        end
        hold = int'($urandom_range(1, 9));
      end
      hold--;
      gray_i      = W'(cur);
      sample_en_i = ($urandom_range(0, 7) != 0);
      clear_err_i = ($urandom_range(0, 15) == 0);
      reset_i     = ($urandom_range(0, 599) == 0);
      tick();
      asserts++;
      if ({bin_o, valid_o, changed_o, dir_o, err_o} !== exp_vec()) begin
        $display("FAIL random n=%0d got=%h want=%h", n,
                 {bin_o, valid_o, changed_o, dir_o, err_o}, exp_vec());
        fails++;
      end
    end
    reset_i = 1'b0; clear_err_i = 1'b0; sample_en_i = 1'b1;
  endtask

  initial begin
    reset_i = 1'b1; gray_i = '0; sample_en_i = 1'b1; clear_err_i = 1'b0;
    test_reset();
    test_step();
    test_glitch();
    test_fault_clear();
    test_wrap();
    test_reset_mid();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", asserts, fails);
    $finish;
  end

endmodule
